// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RSP  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_bundle_t;

    // Sequential PC advance, 32-bit modulo.
    function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and memory.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry holding buffer for a fetched instruction that arrived while decode was stalled.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          drain,
    input  logic          clear,
    input  fetch_bundle_t din,
    output fetch_bundle_t dout,
    output logic          full
);

    fetch_bundle_t data_r;
    logic          full_r;

    // Entry storage; clear wins over load so a flush can never leave stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            full_r <= 1'b0;
        end else if (clear) begin
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= din;
            full_r <= 1'b1;
        end else if (drain) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign dout = data_r;
    assign full = full_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, feeds IF/ID.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 stall_i,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          instruction_output,
    output logic [31:0]          pc_output,
    output logic [31:0]          pcInc_output,
    output logic                 valid_output
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall_cycles
`endif
);

    fetch_state_t  state_r;
    logic [31:0]   pc_r;
    logic          drop_r;
    logic [31:0]   instr_r;
    logic [31:0]   pc_out_r;
    logic [31:0]   pcinc_out_r;
    logic          valid_r;

    logic          accepted_s;
    logic          slot_free_s;
    logic          rsp_keep_s;
    logic          load_rsp_s;
    logic          hold_load_s;
    logic          drain_s;
    logic          hold_full_s;
    fetch_bundle_t hold_din_s;
    fetch_bundle_t hold_dout_s;

    // Request is withdrawn in the redirect cycle so a stale PC is never accepted.
    assign imem.imem_req_valid = (state_r == S_REQ) && !redirect_valid;
    assign imem.imem_addr      = pc_r;

    assign accepted_s  = imem.imem_req_valid && imem.imem_req_ready;
    assign slot_free_s = !valid_r || !stall_i;
    assign rsp_keep_s  = (state_r == S_RSP) && imem.imem_rsp_valid && !drop_r && !redirect_valid;
    assign load_rsp_s  = rsp_keep_s && slot_free_s;
    assign hold_load_s = rsp_keep_s && !slot_free_s;
    assign drain_s     = (state_r == S_HOLD) && hold_full_s && !redirect_valid && !stall_i;
    assign hold_din_s  = '{instr: imem.imem_rsp_data, pc: pc_r};

    fetch_hold_buf u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hold_load_s),
        .drain (drain_s),
        .clear (redirect_valid),
        .din   (hold_din_s),
        .dout  (hold_dout_s),
        .full  (hold_full_s)
    );

    // Fetch sequencer plus the IF/ID output register; redirect outranks stall and loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_REQ;
            pc_r        <= RESET_PC;
            drop_r      <= 1'b0;
            instr_r     <= INSN_NOP;
            pc_out_r    <= 32'h0000_0000;
            pcinc_out_r <= 32'h0000_0000;
            valid_r     <= 1'b0;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_pc;
                    end else if (accepted_s) begin
                        state_r <= S_RSP;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_RSP: begin
                    if (imem.imem_rsp_valid) begin
                        if (drop_r || redirect_valid) begin
                            drop_r  <= 1'b0;
                            state_r <= S_REQ;
                            if (redirect_valid) begin
                                pc_r <= redirect_pc;
                            end else begin
                                pc_r <= pc_r;
                            end
                        end else begin
                            pc_r    <= pc_add(pc_r, PC_STEP);
                            state_r <= slot_free_s ? S_REQ : S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop_r <= 1'b1;
                        pc_r   <= redirect_pc;
                    end else begin
                        state_r <= S_RSP;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_r    <= redirect_pc;
                        state_r <= S_REQ;
                    end else if (!stall_i) begin
                        state_r <= S_REQ;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r <= S_REQ;
                end
            endcase

            if (redirect_valid) begin
                valid_r <= 1'b0;
                instr_r <= INSN_NOP;
            end else if (load_rsp_s) begin
                valid_r     <= 1'b1;
                instr_r     <= imem.imem_rsp_data;
                pc_out_r    <= pc_r;
                pcinc_out_r <= pc_add(pc_r, PC_STEP);
            end else if (drain_s) begin
                valid_r     <= 1'b1;
                instr_r     <= hold_dout_s.instr;
                pc_out_r    <= hold_dout_s.pc;
                pcinc_out_r <= pc_add(hold_dout_s.pc, PC_STEP);
            end else if (valid_r && !stall_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign instruction_output = instr_r;
    assign pc_output          = pc_out_r;
    assign pcInc_output       = pcinc_out_r;
    assign valid_output       = valid_r;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;

    // Event counters; only reset clears them, redirects do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r <= 32'd0;
            perf_stall_r   <= 32'd0;
        end else begin
            if (load_rsp_s || drain_s) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end else begin
                perf_fetched_r <= perf_fetched_r;
            end
            if (valid_r && stall_i) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_fetched      = perf_fetched_r;
    assign perf_stall_cycles = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: two instances (default and wrapping RESET_PC) vs a transaction model.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic [31:0] io0, po0, pio0, io1, po1, pio1;
    logic        vo0, vo1;
`ifdef FETCH_PERF_EN
    logic [31:0] pf0, ps0, pf1, ps1;
`endif

    fetch_stage_if if0();
    fetch_stage_if if1();

    fetch_stage dut0 (
        .clk(clk), .rst_n(rst_n), .imem(if0.master), .stall_i(stall_i),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction_output(io0), .pc_output(po0), .pcInc_output(pio0), .valid_output(vo0)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf0), .perf_stall_cycles(ps0)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n), .imem(if1.master), .stall_i(stall_i),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction_output(io1), .pc_output(po1), .pcInc_output(pio1), .valid_output(vo1)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf1), .perf_stall_cycles(ps1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, what is in flight, buffered and presented.
    logic [31:0] reset_pc [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
    logic [31:0] m_pc [2];
    logic        m_busy [2];
    logic        m_drop [2];
    logic        m_hv [2];
    logic [31:0] m_hi [2];
    logic [31:0] m_hp [2];
    logic        m_vo [2];
    logic [31:0] m_io [2];
    logic [31:0] m_po [2];
    logic [31:0] m_pio [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_pf [2];
    logic [31:0] m_ps [2];
    logic        last_hs;
    int          wait_cyc = -1;
    int          rsp_lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_pc[k] = reset_pc[k]; m_busy[k] = 1'b0; m_drop[k] = 1'b0; m_hv[k] = 1'b0;
        m_hi[k] = 32'd0; m_hp[k] = 32'd0; m_vo[k] = 1'b0; m_io[k] = NOP;
        m_po[k] = 32'd0; m_pio[k] = 32'd0; m_pf[k] = 32'd0; m_ps[k] = 32'd0;
    endtask

    task automatic model_step(input int k, input logic st, input logic rd, input logic [31:0] rp,
                              input logic rdy, input logic rv, input logic [31:0] data);
        logic        load;
        logic [31:0] li, lp;
        logic        consumed;
        load = 1'b0; li = 32'd0; lp = 32'd0;
        consumed = m_vo[k] && !st;
        if (m_vo[k] && st) m_ps[k] = m_ps[k] + 32'd1;
        if (rd) begin
            m_vo[k] = 1'b0; m_io[k] = NOP; m_hv[k] = 1'b0;
            if (m_busy[k]) begin
                if (rv) begin m_busy[k] = 1'b0; m_drop[k] = 1'b0; end
                else m_drop[k] = 1'b1;
            end
            m_pc[k] = rp;
        end else begin
            if (m_hv[k]) begin
                if (!st) begin load = 1'b1; li = m_hi[k]; lp = m_hp[k]; m_hv[k] = 1'b0; end
            end else if (m_busy[k]) begin
                if (rv) begin
                    m_busy[k] = 1'b0;
                    if (m_drop[k]) m_drop[k] = 1'b0;
                    else begin
                        if (!m_vo[k] || !st) begin load = 1'b1; li = data; lp = m_pc[k]; end
                        else begin m_hv[k] = 1'b1; m_hi[k] = data; m_hp[k] = m_pc[k]; end
                        m_pc[k] = m_pc[k] + STEP;
                    end
                end
            end else if (rdy) begin
                m_busy[k] = 1'b1; m_addr[k] = m_pc[k];
                if (k == 0) last_hs = 1'b1;
            end
            if (load) begin
                m_vo[k] = 1'b1; m_io[k] = li; m_po[k] = lp; m_pio[k] = lp + STEP;
                m_pf[k] = m_pf[k] + 32'd1;
            end else if (consumed) m_vo[k] = 1'b0;
        end
    endtask

    task automatic check_inst(input int k, input logic rd);
        logic        rv_g, v_g;
        logic [31:0] a_g, i_g, p_g, pi_g;
        string       u;
        u = $sformatf("u%0d_", k);
        if (k == 0) begin
            rv_g = if0.imem_req_valid; a_g = if0.imem_addr; v_g = vo0; i_g = io0; p_g = po0; pi_g = pio0;
        end else begin
            rv_g = if1.imem_req_valid; a_g = if1.imem_addr; v_g = vo1; i_g = io1; p_g = po1; pi_g = pio1;
        end
        check_eq({u, "req_valid"}, {31'd0, rv_g}, {31'd0, !m_busy[k] && !m_hv[k] && !rd});
        check_eq({u, "imem_addr"}, a_g, m_pc[k]);
        check_eq({u, "valid"}, {31'd0, v_g}, {31'd0, m_vo[k]});
        check_eq({u, "instr"}, i_g, m_io[k]);
        check_eq({u, "pc"}, p_g, m_po[k]);
        check_eq({u, "pcinc"}, pi_g, m_pio[k]);
`ifdef FETCH_PERF_EN
        check_eq({u, "perf_fetched"}, (k == 0) ? pf0 : pf1, m_pf[k]);
        check_eq({u, "perf_stall"}, (k == 0) ? ps0 : ps1, m_ps[k]);
`endif
    endtask

    task automatic cycle(input logic rst, input logic st, input logic rd, input logic [31:0] rp,
                         input logic rdy, input logic rv);
        logic [31:0] d0, d1;
        @(negedge clk);
        d0 = mem_word(m_addr[0]);
        d1 = mem_word(m_addr[1]);
        rst_n = rst; stall_i = st; redirect_valid = rd; redirect_pc = rp;
        if0.imem_req_ready = rdy; if1.imem_req_ready = rdy;
        if0.imem_rsp_valid = rv;  if1.imem_rsp_valid = rv;
        if0.imem_rsp_data  = d0;  if1.imem_rsp_data  = d1;
        #1;
        last_hs = 1'b0;
        if (!rst) begin model_reset(0); model_reset(1); end
        check_inst(0, rd);
        check_inst(1, rd);
        if (rst) begin
            model_step(0, st, rd, rp, rdy, rv, d0);
            model_step(1, st, rd, rp, rdy, rv, d1);
        end
    endtask

    task automatic run(input logic rst, input logic st, input logic rd, input logic [31:0] rp,
                       input logic rdy);
        logic rv;
        rv = rst && (wait_cyc == 0);
        cycle(rst, st, rd, rp, rdy, rv);
        if (!rst) wait_cyc = -1;
        else begin
            if (rv) wait_cyc = -1;
            else if (wait_cyc > 0) wait_cyc--;
            if (last_hs) wait_cyc = (rsp_lat < 0) ? int'($urandom_range(0, 2)) : rsp_lat;
        end
    endtask

    initial begin
        int stall_left;
        logic st, rd, rdy;
        logic [31:0] rp;
        m_addr[0] = 32'd0; m_addr[1] = 32'd0;
        model_reset(0); model_reset(1);
        if0.imem_req_ready = 1'b0; if1.imem_req_ready = 1'b0;
        if0.imem_rsp_valid = 1'b0; if1.imem_rsp_valid = 1'b0;
        if0.imem_rsp_data = 32'd0; if1.imem_rsp_data = 32'd0;

        // Reset, then zero-wait streaming.
        repeat (2) run(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        rsp_lat = 0;
        repeat (6) run(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        // Long stall with a response landing in the hold buffer.
        repeat (6) run(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        repeat (4) run(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        // Redirect while a slow response is outstanding.
        rsp_lat = 2;
        for (int i = 0; i < 10 && !m_busy[0]; i++) run(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        run(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        repeat (6) run(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        // Redirect coincident with a response under stall.
        rsp_lat = 0;
        for (int i = 0; i < 10 && !m_busy[0]; i++) run(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        run(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        repeat (4) run(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        // Reset mid-transaction followed by a late response.
        for (int i = 0; i < 10 && !m_busy[0]; i++) run(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        wait_cyc = -1;
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        repeat (4) run(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

        // Randomized traffic.
        rsp_lat = -1;
        stall_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (stall_left > 0) begin st = 1'b1; stall_left--; end
            else if ($urandom_range(0, 3) == 0) begin st = 1'b1; stall_left = $urandom_range(0, 6); end
            else st = 1'b0;
            rd  = ($urandom_range(0, 9) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) run(1'b0, st, rd, rp, rdy);
            else run(1'b1, st, rd, rp, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
